// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC register-address sequencer: the sequencer
// state encoding and the index-to-register-address table.
package rtc_pkg;

    localparam int RTC_TABLE_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } rtc_state_t;

    // Seconds/minutes block at 0x21.., alarm block at 0x41.., control at 0xF0.
    function automatic logic [RTC_TABLE_ADDR_W-1:0] rtc_table_addr(input int unsigned index);
        case (index)
            0:       return 8'h00;
            1:       return 8'h21;
            2:       return 8'h22;
            3:       return 8'h23;
            4:       return 8'h24;
            5:       return 8'h25;
            6:       return 8'h26;
            7:       return 8'h41;
            8:       return 8'h42;
            9:       return 8'h43;
            10:      return 8'hF0;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/rtc_addr_map.sv
// Combinational index-to-register-address lookup; entries at or beyond
// N_REG read as address zero.
module rtc_addr_map
    import rtc_pkg::*;
#(
    parameter int N_REG  = 11,
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 4
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] addr
);

    always_comb begin
        addr = '0;
        if (32'(idx) < N_REG) begin
            addr = ADDR_W'(rtc_table_addr(32'(idx)));
        end
    end

endmodule

// File: rtl/rtc_addr_sequencer.sv
// Walks the RTC register-address table, issuing one bus request per entry,
// either as a full sweep or as a single indexed access.
module rtc_addr_sequencer
    import rtc_pkg::*;
#(
    parameter int N_REG  = 11,
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              start,
    input  logic              mode,
    input  logic [IDX_W-1:0]  idx_in,
    input  logic              wr_in,
    input  logic              bus_done,
    output logic [ADDR_W-1:0] addr_out,
    output logic [IDX_W-1:0]  idx_out,
    output logic              req,
    output logic              rw,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REG - 1);

    rtc_state_t        state;
    logic              mode_q;
    logic [IDX_W-1:0]  start_idx;
    logic [IDX_W-1:0]  map_idx;
    logic [ADDR_W-1:0] map_addr;
    logic              idx_valid;
    logic              last_entry;

    // The single map instance looks up the start entry while idle and the
    // following entry otherwise, so the address is ready when REQ is entered.
    always_comb begin
        start_idx  = mode ? idx_in : '0;
        map_idx    = (state == ST_IDLE) ? start_idx : idx_out + IDX_W'(1);
        idx_valid  = (32'(idx_in) < N_REG);
        last_entry = mode_q || (idx_out == LAST_IDX);
    end

    rtc_addr_map #(
        .N_REG  (N_REG),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_addr_map (
        .idx  (map_idx),
        .addr (map_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            mode_q   <= 1'b0;
            idx_out  <= '0;
            addr_out <= '0;
            req      <= 1'b0;
            rw       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start && en) begin
                        if (mode && !idx_valid) begin
                            err <= 1'b1;
                        end else begin
                            mode_q   <= mode;
                            rw       <= wr_in;
                            idx_out  <= start_idx;
                            addr_out <= map_addr;
                            req      <= 1'b1;
                            busy     <= 1'b1;
                            state    <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_done) begin
                        req <= 1'b0;
                        // Losing enable lets the current access finish but stops the walk.
                        if (last_entry || !en) begin
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (en) begin
                        idx_out  <= map_idx;
                        addr_out <= map_addr;
                        req      <= 1'b1;
                        state    <= ST_REQ;
                    end else begin
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_addr_sequencer.sv
// Bench for rtc_addr_sequencer: table-driven and randomized operations checked
// against an access-list model, plus reset and enable corner sequences.
module tb_rtc_addr_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] idx_in = 4'd0;
    logic       wr_in = 1'b0;
    logic       bus_done = 1'b0;
    logic [7:0] addr_out;
    logic [3:0] idx_out;
    logic       req;
    logic       rw;
    logic       busy;
    logic       done;
    logic       err;

    rtc_addr_sequencer #(
        .N_REG  (11),
        .ADDR_W (8),
        .IDX_W  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .start    (start),
        .mode     (mode),
        .idx_in   (idx_in),
        .wr_in    (wr_in),
        .bus_done (bus_done),
        .addr_out (addr_out),
        .idx_out  (idx_out),
        .req      (req),
        .rw       (rw),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [3:0] idx;
        logic       rw;
    } access_t;

    typedef struct {
        bit         mode;
        logic [3:0] idx;
        bit         wr;
        int         delay;
        int         drop_at;
        bit         repulse;
        bit         exp_err;
        int         exp_count;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } vec_t;

    logic [7:0] ref_addr [0:10] = '{8'h00, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                                    8'h26, 8'h41, 8'h42, 8'h43, 8'hF0};

    int      vec_cnt = 0;
    int      miss_cnt = 0;
    access_t obs_q[$];
    access_t exp_q[$];
    int      obs_hold[$];
    int      obs_gap[$];
    int      obs_err;
    int      obs_done;
    int      done_sample;
    int      last_req_sample;
    int      stable_fail;
    bit      op_finished;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            miss_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference: the list of accesses an operation should produce.
    function automatic void modelOp(input bit m, input logic [3:0] ix, input bit w, input int drop_at,
                                    output bit e_err, output bit e_done);
        int first;
        int last;
        exp_q.delete();
        e_err  = 1'b0;
        e_done = 1'b0;
        if (m && int'(ix) >= 11) begin
            e_err = 1'b1;
            return;
        end
        first = m ? int'(ix) : 0;
        last  = m ? int'(ix) : 10;
        if (drop_at >= first && drop_at < last) last = drop_at;
        for (int i = first; i <= last; i++) exp_q.push_back('{ref_addr[i], 4'(i), w});
        e_done = 1'b1;
    endfunction

    // Issue one operation and play the bus side, recording what the DUT emits.
    task automatic applyStimulus(input bit m, input logic [3:0] ix, input bit w, input int delay,
                                 input int drop_at, input bit repulse);
        int cyc;
        int hold;
        int low_run;
        int settle;
        bit prev_req;
        bit acked;
        obs_q.delete();
        obs_hold.delete();
        obs_gap.delete();
        obs_err = 0;
        obs_done = 0;
        done_sample = -1;
        last_req_sample = -1;
        stable_fail = 0;
        op_finished = 1'b0;
        hold = 0;
        acked = 1'b0;
        mode = m;
        idx_in = ix;
        wr_in = w;
        en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        prev_req = 1'b0;
        low_run = 0;
        settle = 0;
        while (!op_finished && cyc < 400) begin
            bus_done = 1'b0;
            start = 1'b0;
            if (err) obs_err++;
            if (done) begin
                obs_done++;
                done_sample = cyc;
            end
            if (req) begin
                if (!prev_req) begin
                    obs_q.push_back('{addr_out, idx_out, rw});
                    obs_gap.push_back(low_run);
                    hold = 0;
                    acked = 1'b0;
                    if (drop_at >= 0 && int'(idx_out) == drop_at) en = 1'b0;
                    if (repulse && obs_q.size() == 4) start = 1'b1;
                end else if (obs_q[obs_q.size()-1] != '{addr_out, idx_out, rw}) begin
                    stable_fail++;
                end
                hold++;
                low_run = 0;
                if (!acked && hold == delay + 1) begin
                    bus_done = 1'b1;
                    acked = 1'b1;
                end
                last_req_sample = cyc;
            end else begin
                if (prev_req) obs_hold.push_back(hold);
                low_run++;
            end
            prev_req = req;
            if (!busy) begin
                settle++;
                if (repulse && settle == 1) bus_done = 1'b1;
            end else begin
                settle = 0;
            end
            if (settle >= 3) op_finished = 1'b1;
            tick();
            cyc++;
        end
        bus_done = 1'b0;
        start = 1'b0;
        en = 1'b1;
    endtask

    task automatic runAndCheck(input bit m, input logic [3:0] ix, input bit w, input int delay,
                               input int drop_at, input bit repulse);
        bit e_err;
        bit e_done;
        int n;
        applyStimulus(m, ix, w, delay, drop_at, repulse);
        modelOp(m, ix, w, drop_at, e_err, e_done);
        checkOutput("op_terminated", 32'(op_finished), 32'd1);
        checkOutput("access_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("addr[%0d]", i), 32'(obs_q[i].addr), 32'(exp_q[i].addr));
            checkOutput($sformatf("idx[%0d]", i), 32'(obs_q[i].idx), 32'(exp_q[i].idx));
            checkOutput($sformatf("rw[%0d]", i), 32'(obs_q[i].rw), 32'(exp_q[i].rw));
            checkOutput($sformatf("gap[%0d]", i), obs_gap[i], (i == 0) ? 0 : 1);
            if (i < obs_hold.size()) checkOutput($sformatf("hold[%0d]", i), obs_hold[i], delay + 1);
        end
        checkOutput("err_pulses", obs_err, e_err ? 1 : 0);
        checkOutput("done_pulses", obs_done, e_done ? 1 : 0);
        if (e_done) checkOutput("done_timing", done_sample, last_req_sample + 1);
        checkOutput("req_stable", stable_fail, 0);
        checkOutput("busy_after_op", 32'(busy), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #2;
        checkOutput("async_reset_req", 32'(req), 32'd0);
        checkOutput("async_reset_busy", 32'(busy), 32'd0);
        tick();
        tick();
        checkOutput("reset_addr", 32'(addr_out), 32'h00);
        checkOutput("reset_idx", 32'(idx_out), 32'd0);
        checkOutput("reset_rw", 32'(rw), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        reset = 1'b0;
        tick();

        // Start with enable low is ignored, even for an illegal single index
        en = 1'b0;
        mode = 1'b1;
        idx_in = 4'd12;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("en0_busy", 32'(busy), 32'd0);
        checkOutput("en0_req", 32'(req), 32'd0);
        checkOutput("en0_err", 32'(err), 32'd0);
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        checkOutput("idle_bus_done_busy", 32'(busy), 32'd0);
        checkOutput("idle_bus_done_req", 32'(req), 32'd0);

        // Table-driven operations
        vecs.push_back('{1'b0, 4'd0,  1'b0, 0, -1, 1'b0, 1'b0, 11, 8'h00, 8'hF0});
        vecs.push_back('{1'b1, 4'd7,  1'b1, 5, -1, 1'b0, 1'b0, 1,  8'h41, 8'h41});
        vecs.push_back('{1'b1, 4'd12, 1'b0, 0, -1, 1'b0, 1'b1, 0,  8'h00, 8'h00});
        vecs.push_back('{1'b0, 4'd0,  1'b0, 1, -1, 1'b1, 1'b0, 11, 8'h00, 8'hF0});
        vecs.push_back('{1'b0, 4'd0,  1'b0, 1, 3,  1'b0, 1'b0, 4,  8'h00, 8'h23});
        vecs.push_back('{1'b1, 4'd10, 1'b0, 1, -1, 1'b0, 1'b0, 1,  8'hF0, 8'hF0});
        vecs.push_back('{1'b1, 4'd0,  1'b1, 2, -1, 1'b0, 1'b0, 1,  8'h00, 8'h00});
        vecs.push_back('{1'b1, 4'd11, 1'b1, 0, -1, 1'b0, 1'b1, 0,  8'h00, 8'h00});
        vecs.push_back('{1'b1, 4'd15, 1'b0, 0, -1, 1'b0, 1'b1, 0,  8'h00, 8'h00});
        vecs.push_back('{1'b0, 4'd0,  1'b1, 2, 10, 1'b0, 1'b0, 11, 8'h00, 8'hF0});
        vecs.push_back('{1'b1, 4'd6,  1'b0, 3, 6,  1'b0, 1'b0, 1,  8'h26, 8'h26});
        for (int v = 0; v < vecs.size(); v++) begin
            runAndCheck(vecs[v].mode, vecs[v].idx, vecs[v].wr, vecs[v].delay, vecs[v].drop_at, vecs[v].repulse);
            checkOutput($sformatf("v%0d_err", v), obs_err, vecs[v].exp_err ? 1 : 0);
            checkOutput($sformatf("v%0d_count", v), obs_q.size(), vecs[v].exp_count);
            if (vecs[v].exp_count > 0 && obs_q.size() > 0) begin
                checkOutput($sformatf("v%0d_first", v), 32'(obs_q[0].addr), 32'(vecs[v].exp_first));
                checkOutput($sformatf("v%0d_last", v), 32'(obs_q[obs_q.size()-1].addr), 32'(vecs[v].exp_last));
            end
        end

        // Randomized operations
        for (int n = 0; n < 24; n++) begin
            bit         rm;
            logic [3:0] rix;
            bit         rw_r;
            int         rdel;
            int         rdrop;
            rm    = 1'($urandom_range(0, 1));
            rix   = 4'($urandom_range(0, 15));
            rw_r  = 1'($urandom_range(0, 1));
            rdel  = int'($urandom_range(0, 3));
            rdrop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
            runAndCheck(rm, rix, rw_r, rdel, rdrop, 1'b0);
        end

        // Reset in the middle of the access at index 5
        begin
            bit found;
            int saw_done;
            found = 1'b0;
            saw_done = 0;
            mode = 1'b0;
            wr_in = 1'b0;
            en = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 0; c < 100 && !found; c++) begin
                bus_done = 1'b0;
                if (req && idx_out == 4'd5) begin
                    found = 1'b1;
                end else begin
                    if (req) bus_done = 1'b1;
                    tick();
                end
            end
            checkOutput("reach_idx5", 32'(found), 32'd1);
            checkOutput("pre_reset_addr", 32'(addr_out), 32'h25);
            #1 reset = 1'b1;
            #1;
            checkOutput("mid_reset_req", 32'(req), 32'd0);
            checkOutput("mid_reset_busy", 32'(busy), 32'd0);
            checkOutput("mid_reset_addr", 32'(addr_out), 32'h00);
            for (int c = 0; c < 3; c++) begin
                tick();
                if (done) saw_done++;
            end
            reset = 1'b0;
            for (int c = 0; c < 4; c++) begin
                tick();
                if (done) saw_done++;
            end
            checkOutput("reset_no_done", saw_done, 0);
            checkOutput("post_reset_busy", 32'(busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
